// File: rtl/prog_loader.sv
// Program loader: buffers a host byte stream, bursts 16 words into the core, then reports portout changes.
// Optional checksum trailer byte is enabled with `define LOADER_CHKSUM_EN.
module prog_loader #(
   parameter int         DEPTH    = 16,
   parameter logic [7:0] PAD_WORD = 8'hA0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_last,
   input  logic       halt,
   output logic       PC_reset,
   output logic       mem_write,
   output logic [3:0] instr,
   output logic [3:0] portin,
   input  logic [3:0] portout,
   output logic       running,
   output logic       out_valid,
   output logic [3:0] out_data,
   output logic       len_err,
   output logic       chk_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
   localparam logic [AW-1:0] LAST_K   = AW'(DEPTH - 1);
`ifdef LOADER_CHKSUM_EN
   localparam logic [CW-1:0] CHK_IDX  = CW'(DEPTH);
`endif

   typedef enum logic [1:0] {IDLE, FILL, LOAD, RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] k_q, k_d;
   logic [7:0]    buf_q [DEPTH];
   logic [7:0]    buf_d [DEPTH];
   logic          len_err_q, len_err_d;
   logic          chk_err_q, chk_err_d;
`ifdef LOADER_CHKSUM_EN
   logic [7:0]    sum_q, sum_d;
   logic [7:0]    sum_base, sum_next;
`endif

   logic          in_ready_q, in_ready_d;
   logic          pc_reset_q, pc_reset_d;
   logic          mem_write_q, mem_write_d;
   logic [3:0]    instr_q, instr_d;
   logic [3:0]    portin_q, portin_d;
   logic          running_q, running_d;
   logic          out_valid_q, out_valid_d;
   logic [3:0]    out_data_q, out_data_d;
   logic [3:0]    last_out_q, last_out_d;

   logic          accept;
   logic          start;
   logic [CW-1:0] base_cnt;
   logic [7:0]    word;

   assign accept = in_valid & in_ready_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         k_q         <= '0;
         len_err_q   <= 1'b0;
         chk_err_q   <= 1'b0;
`ifdef LOADER_CHKSUM_EN
         sum_q       <= '0;
`endif
         in_ready_q  <= 1'b0;
         pc_reset_q  <= 1'b1;
         mem_write_q <= 1'b0;
         instr_q     <= '0;
         portin_q    <= '0;
         running_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         last_out_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         len_err_q   <= len_err_d;
         chk_err_q   <= chk_err_d;
`ifdef LOADER_CHKSUM_EN
         sum_q       <= sum_d;
`endif
         in_ready_q  <= in_ready_d;
         pc_reset_q  <= pc_reset_d;
         mem_write_q <= mem_write_d;
         instr_q     <= instr_d;
         portin_q    <= portin_d;
         running_q   <= running_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         last_out_q  <= last_out_d;
      end
   end

   // Buffer contents need no reset: the stored count decides what is real and what is padding.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      buf_d     = buf_q;
      len_err_d = len_err_q;
      chk_err_d = 1'b0;
      start     = accept && (state_q == IDLE || state_q == RUN);
      base_cnt  = start ? '0 : cnt_q;
`ifdef LOADER_CHKSUM_EN
      sum_d     = sum_q;
      sum_base  = start ? 8'h00 : sum_q;
      sum_next  = sum_base + in_data;
`endif
      if (start) len_err_d = 1'b0;
      case (state_q)
         IDLE, FILL, RUN: begin
            if (accept) begin
               cnt_d = base_cnt;
`ifdef LOADER_CHKSUM_EN
               if (in_last || base_cnt == CHK_IDX) begin
                  if (!in_last) len_err_d = 1'b1;
                  if (sum_next == 8'h00) begin
                     state_d = LOAD;
                     k_d     = '0;
                  end else begin
                     state_d   = IDLE;
                     chk_err_d = 1'b1;
                  end
               end else begin
                  buf_d[base_cnt[AW-1:0]] = in_data;
                  cnt_d   = base_cnt + 1'b1;
                  sum_d   = sum_next;
                  state_d = FILL;
               end
`else
               buf_d[base_cnt[AW-1:0]] = in_data;
               cnt_d = base_cnt + 1'b1;
               if (in_last || base_cnt == LAST_IDX) begin
                  if (!in_last) len_err_d = 1'b1;
                  state_d = LOAD;
                  k_d     = '0;
               end else begin
                  state_d = FILL;
               end
`endif
            end else if (state_q == RUN && halt) begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            k_d = k_q + 1'b1;
            if (k_q == LAST_K) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   // Port values lag the state by one cycle; in_ready looks ahead so no byte is taken during LOAD.
   always_comb begin
      pc_reset_d  = (state_q == IDLE) || (state_q == FILL);
      mem_write_d = (state_q == LOAD);
      running_d   = (state_q == RUN);
      in_ready_d  = (state_d != LOAD);
      word        = (CW'(k_q) < cnt_q) ? buf_q[k_q] : PAD_WORD;
      {instr_d, portin_d} = mem_write_d ? word : 8'h00;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      last_out_d  = last_out_q;
      if (state_q == RUN && portout != last_out_q) begin
         out_valid_d = 1'b1;
         out_data_d  = portout;
         last_out_d  = portout;
      end else if (state_q == LOAD && state_d == RUN) begin
         last_out_d  = portout;
      end
   end

   assign in_ready  = in_ready_q;
   assign PC_reset  = pc_reset_q;
   assign mem_write = mem_write_q;
   assign instr     = instr_q;
   assign portin    = portin_q;
   assign running   = running_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign len_err   = len_err_q;
   assign chk_err   = chk_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader (default build): random programs checked against a queue-based model of the load burst.
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_last;
   logic       halt;
   logic       PC_reset;
   logic       mem_write;
   logic [3:0] instr;
   logic [3:0] portin;
   logic [3:0] portout;
   logic       running;
   logic       out_valid;
   logic [3:0] out_data;
   logic       len_err;
   logic       chk_err;

   int         checks = 0;
   int         passed = 0;
   logic [7:0] model_prog [$];

   always #5 clk = ~clk;

   prog_loader dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .halt(halt), .PC_reset(PC_reset),
      .mem_write(mem_write), .instr(instr), .portin(portin), .portout(portout),
      .running(running), .out_valid(out_valid), .out_data(out_data),
      .len_err(len_err), .chk_err(chk_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   // One handshake after an idle gap; waits a bounded time for in_ready.
   task automatic applyStimulus(input logic [7:0] data, input logic last, input int gap);
      int waited = 0;
      for (int i = 0; i < gap; i++) tick();
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      while (!in_ready && waited < 40) begin
         tick();
         waited++;
      end
      checkOutput("in_ready_wait", in_ready, 1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   function automatic logic [7:0] expWord(input int k);
      return (k < model_prog.size()) ? model_prog[k] : 8'hA0;
   endfunction

   task automatic sendModel(input int from, input logic with_last, input int maxgap);
      for (int i = from; i < model_prog.size(); i++)
         applyStimulus(model_prog[i], with_last && (i == model_prog.size() - 1),
                       int'($urandom_range(0, maxgap)));
   endtask

   task automatic fillRandom(input int n);
      model_prog.delete();
      for (int i = 0; i < n; i++) model_prog.push_back(8'($urandom));
   endtask

   // Called one cycle-fraction after the final accept; expects 16 contiguous words then RUN.
   task automatic checkBurst(input logic exp_len_err);
      checkOutput("pre_burst_mem_write", mem_write, 0);
      checkOutput("load_in_ready", in_ready, 0);
      for (int k = 0; k < 16; k++) begin
         tick();
         checkOutput($sformatf("word%0d", k), {PC_reset, mem_write, instr, portin},
                     {1'b0, 1'b1, expWord(k)});
      end
      tick();
      checkOutput("run_entry", {mem_write, running, PC_reset, instr, portin},
                  {1'b0, 1'b1, 1'b0, 8'h00});
      checkOutput("len_err", len_err, exp_len_err);
      checkOutput("chk_err", chk_err, 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [3:0] seq [5];
      logic [3:0] prev;
      int         pulses;
      int         n;
      logic       lastf;

      reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
      halt = 1'b0; portout = 4'h0;
      tick();
      tick();
      checkOutput("rst_pc_reset", PC_reset, 1);
      checkOutput("rst_mem_write", mem_write, 0);
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_instr_portin", {instr, portin}, 8'h00);
      checkOutput("rst_flags", {running, out_valid, out_data, len_err, chk_err}, 8'h00);
      reset = 1'b0;
      tick();
      checkOutput("idle_in_ready", in_ready, 1);

      halt = 1'b1;
      tick();
      halt = 1'b0;
      tick();
      checkOutput("idle_halt_ignored", {PC_reset, running, mem_write}, 3'b100);

      $display("[TB] directed program 63 70 A0");
      model_prog = '{8'h63, 8'h70, 8'hA0};
      sendModel(0, 1'b1, 0);
      checkBurst(1'b0);

      $display("[TB] portout reporting");
      seq = '{4'h0, 4'h5, 4'h5, 4'h9, 4'h9};
      prev = 4'h0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         portout = seq[i];
         tick();
         checkOutput($sformatf("out_valid%0d", i), out_valid, seq[i] != prev);
         if (seq[i] != prev) checkOutput($sformatf("out_data%0d", i), out_data, seq[i]);
         pulses += int'(out_valid);
         prev = seq[i];
      end
      checkOutput("pulse_count", pulses, 2);

      halt = 1'b1;
      tick();
      halt = 1'b0;
      tick();
      checkOutput("halt_to_idle", {PC_reset, running, in_ready, mem_write}, 4'b1010);

      $display("[TB] 16 bytes without in_last, random gaps");
      fillRandom(16);
      sendModel(0, 1'b0, 5);
      checkBurst(1'b1);

      $display("[TB] restart from RUN");
      fillRandom(5);
      applyStimulus(model_prog[0], 1'b0, 0);
      checkOutput("restart_pc_still_low", PC_reset, 0);
      checkOutput("restart_len_err_cleared", len_err, 0);
      tick();
      checkOutput("restart_pc_rises", PC_reset, 1);
      sendModel(1, 1'b1, 3);
      checkBurst(1'b0);

      $display("[TB] random programs");
      for (int r = 0; r < 5; r++) begin
         n = int'($urandom_range(1, 16));
         lastf = (n < 16) ? 1'b1 : 1'($urandom);
         fillRandom(n);
         sendModel(0, lastf, 5);
         checkBurst(n == 16 && !lastf);
      end

      $display("[TB] reset during LOAD");
      fillRandom(2);
      sendModel(0, 1'b1, 0);
      for (int k = 0; k < 8; k++) tick();
      checkOutput("load_word7", {mem_write, instr, portin}, {1'b1, expWord(7)});
      reset = 1'b1;
      tick();
      checkOutput("load_reset", {mem_write, PC_reset}, 2'b01);
      reset = 1'b0;
      tick();
      checkOutput("load_reset_idle", {mem_write, PC_reset, in_ready}, 3'b011);

      $display("[TB] reset during FILL");
      fillRandom(3);
      sendModel(0, 1'b0, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      checkOutput("fill_reset_idle", {mem_write, PC_reset}, 2'b01);
      fillRandom(1);
      sendModel(0, 1'b1, 2);
      checkBurst(1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
